// File: rtl/hazard_ctrl.sv
// IF/ID, PC and ID/EX sequencing for the 5-stage core: load-use stalls,
// taken-branch squash, MUL/DIV front-end stall, and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_muldiv,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_start,
  output logic             mdu_abort,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MDU_BUSY, MDU_DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               lu;
  logic               hold_c, flush_c, bubble_c, start_c, abort_c, busy_c;

  assign lu = ex_memread && (ex_rt != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_c   = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    start_c  = 1'b0;
    abort_c  = 1'b0;
    busy_c   = 1'b0;
    case (state_q)
      RUN, MDU_DONE: begin
        state_d = RUN;
        if (branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (lu) begin
          hold_c   = 1'b1;
          bubble_c = 1'b1;
        end else if (id_is_muldiv && state_q == RUN) begin
          // MDU_DONE still holds the same MUL/DIV in ID, so it must not re-issue
          start_c  = 1'b1;
          hold_c   = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = 8'(MDU_LATENCY - 1);
          state_d  = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        busy_c   = 1'b1;
        bubble_c = 1'b1;
        if (branch_taken) begin
          abort_c = 1'b1;
          flush_c = 1'b1;
          cnt_d   = 8'd0;
          state_d = RUN;
        end else begin
          hold_c = 1'b1;
          if (cnt_q != 8'd0) cnt_d   = cnt_q - 8'd1;
          else               state_d = MDU_DONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hold_c && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign pc_hold     = hold_c   & ~reset;
  assign ifid_hold   = hold_c   & ~reset;
  assign ifid_flush  = flush_c  & ~reset;
  assign idex_bubble = bubble_c & ~reset;
  assign mdu_start   = start_c  & ~reset;
  assign mdu_abort   = abort_c  & ~reset;
  assign mdu_busy    = busy_c   & ~reset;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF/ID register, PC register and ID/EX register of the 5-stage MIPS32 core.
- Generates the hold and flush controls the IF/ID register consumes.
- Detects load-use hazards, squashes wrong-path instructions on taken branches, and stalls the front end for the multi-cycle MUL/DIV unit.
- Keeps a saturating count of stalled cycles for performance debugging.

Parameters:
- MDU_LATENCY, 4, number of cycles the MUL/DIV unit stays busy after mdu_start; legal range 1..255.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  instruction in ID reads rs.
- id_uses_rt  in  1  instruction in ID reads rt.
- id_is_muldiv  in  1  instruction in ID is MULT/MULTU/DIV/DIVU.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  taken branch or jump resolved in EX this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its contents (drives the IF/ID hold input).
- ifid_flush  out  1  IF/ID loads zero (NOP) on the next edge (drives the IF/ID reset input).
- idex_bubble  out  1  ID/EX loads a NOP on the next edge.
- mdu_start  out  1  one-cycle pulse that starts the MUL/DIV unit.
- mdu_abort  out  1  one-cycle pulse that cancels an in-flight MUL/DIV.
- mdu_busy  out  1  high while in MDU_BUSY.
- stall_cnt  out  CNT_W  count of cycles with pc_hold=1.

Behaviour:
- State register: RUN, MDU_BUSY, MDU_DONE. Down-counter cnt is 8 bits.
- Outputs are a combinational decode of state and inputs. While reset=1, every output is forced to 0.
- Async reset: state goes to RUN, cnt goes to 0, stall_cnt goes to 0, immediately and independent of clk.
- Load-use hazard (lu) is asserted when all of the following hold:
  - ex_memread=1 and ex_rt != 0;
  - (id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt).
- RUN and MDU_DONE, priority order:
  1. branch_taken: ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0. lu and muldiv are ignored; the ID instruction is squashed. Next state is RUN.
  2. lu: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly this cycle. Next state is RUN.
  3. id_is_muldiv, RUN only: mdu_start=1, pc_hold=1, ifid_hold=1, idex_bubble=1, cnt loads MDU_LATENCY-1. Next state is MDU_BUSY.
  4. Otherwise all controls are 0. Next state is RUN.
  - In MDU_DONE, id_is_muldiv is ignored (same instruction), so no re-start.
- MDU_BUSY:
  - mdu_busy=1, pc_hold=1, ifid_hold=1, idex_bubble=1.
  - If cnt != 0: cnt decrements. If cnt==0: next state is MDU_DONE.
  - The state lasts exactly MDU_LATENCY cycles.
  - branch_taken in MDU_BUSY (abnormal; must still be safe): mdu_abort=1, ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0, mdu_busy=1 this cycle. Next state is RUN, cnt goes to 0.
- MDU_DONE lasts one cycle. Holds deassert, so the MUL/DIV instruction advances to EX.
- Total front-end stall per MUL/DIV is MDU_LATENCY+1 cycles (the issue cycle plus the BUSY cycles).
- Simultaneous pc_hold and ifid_flush never occur. ifid_hold=pc_hold in every state.
- stall_cnt increments on every rising edge where pc_hold=1 and saturates at all-ones (no wrap).

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for 1 cycle -> pc_hold=ifid_hold=idex_bubble=1 for 1 cycle, then 0; stall_cnt 0->1.
- Zero register: ex_memread=1, ex_rt=0, id_rs=0, id_uses_rs=1 -> no stall, all controls 0, stall_cnt stays 0.
- Branch wins: branch_taken=1 with lu conditions true and id_is_muldiv=1 -> ifid_flush=1, idex_bubble=1, pc_hold=0, mdu_start=0; state stays RUN.
- MUL/DIV, MDU_LATENCY=4: id_is_muldiv=1 held -> mdu_start pulses once; pc_hold=1 for 5 consecutive cycles; mdu_busy=1 for 4; 6th cycle all 0 (MDU_DONE); no second mdu_start; stall_cnt=5.
- Abort: branch_taken=1 in 2nd MDU_BUSY cycle -> mdu_abort=1, ifid_flush=1, pc_hold=0 that cycle; next cycle state RUN, mdu_busy=0.
- Reset mid-op: assert reset between clock edges in MDU_BUSY with stall_cnt=3 -> outputs 0 immediately, stall_cnt=0; after release, state RUN and idle inputs give all controls 0.
